// File: rtl/sirv_gnrl_sync_fifo.sv
// Synchronous valid/ready FIFO with a registered occupancy count.
// It has no bypass, so each word sits in the register array for at least one cycle.
module sirv_gnrl_sync_fifo #(
    parameter int DP = 4,
    parameter int DW = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_vld,
    output logic                   i_rdy,
    input  logic [DW-1:0]          i_dat,
    output logic                   o_vld,
    input  logic                   o_rdy,
    output logic [DW-1:0]          o_dat,
    output logic [$clog2(DP):0]    cnt
);

    localparam int AW = $clog2(DP);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [DW-1:0] mem_q [DP];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty, full, push, pop;

    // The MSB of each pointer is the wrap flag that separates full from empty.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        i_rdy = !full;
        o_vld = !empty;
        push  = i_vld && i_rdy;
        pop   = o_vld && o_rdy;
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + ONE;
        if (pop)  rptr_d = rptr_q + ONE;
        if (push && !pop) cnt_d = cnt_q + ONE;
        if (pop && !push) cnt_d = cnt_q - ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= i_dat;
    end

    always_comb begin
        o_dat = '0;
        if (o_vld) o_dat = mem_q[rptr_q[AW-1:0]];
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_sirv_gnrl_sync_fifo.sv
// Bench for sirv_gnrl_sync_fifo: directed scenarios plus random stress
// against a queue model of the FIFO.
module tb_sirv_gnrl_sync_fifo;

    localparam int DP = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [2:0]    cnt;

    int checks = 0;
    int passes = 0;
    logic [DW-1:0] model[$];

    sirv_gnrl_sync_fifo #(.DP(DP), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_vld (i_vld),
        .i_rdy (i_rdy),
        .i_dat (i_dat),
        .o_vld (o_vld),
        .o_rdy (o_rdy),
        .o_dat (o_dat),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    // One clock edge; the model applies the handshake rules from its own occupancy.
    task automatic tick();
        bit p, q;
        p = i_vld && (model.size() < DP);
        q = o_rdy && (model.size() > 0);
        @(posedge clk);
        if (rst) model.delete();
        else begin
            if (q) void'(model.pop_front());
            if (p) model.push_back(i_dat);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; i_vld = 1; i_dat = 8'hAA; o_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (o_vld !== 1'b0 || i_rdy !== 1'b1 || cnt !== 3'd0 || o_dat !== 8'h00)
                $display("FAIL reset: o_vld=%b i_rdy=%b cnt=%0d o_dat=%h want 0 1 0 00",
                         o_vld, i_rdy, cnt, o_dat);
            else passes++;
        end
        rst = 0; i_vld = 0; o_rdy = 0;
        tick();
        checks++;
        if (o_vld !== 1'b0 || cnt !== 3'd0)
            $display("FAIL reset_nostore: o_vld=%b cnt=%0d want 0 0", o_vld, cnt);
        else passes++;
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] exp;
        o_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            i_vld = 1; i_dat = 8'((i + 1) * 'h11);
            tick();
            checks++;
            if (cnt !== 3'(i + 1) || o_dat !== 8'h11 || i_rdy !== (i != 3))
                $display("FAIL fill%0d: cnt=%0d o_dat=%h i_rdy=%b want %0d 11 %b",
                         i, cnt, o_dat, i_rdy, i + 1, i != 3);
            else passes++;
        end
        i_dat = 8'h55;
        tick();
        checks++;
        if (cnt !== 3'd4 || o_dat !== 8'h11)
            $display("FAIL fill_refuse: cnt=%0d o_dat=%h want 4 11", cnt, o_dat);
        else passes++;
        i_vld = 0; o_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            exp = 8'((i + 1) * 'h11);
            checks++;
            if (o_vld !== 1'b1 || o_dat !== exp)
                $display("FAIL drain%0d: o_vld=%b o_dat=%h want 1 %h", i, o_vld, o_dat, exp);
            else passes++;
            tick();
        end
        checks++;
        if (o_vld !== 1'b0 || o_dat !== 8'h00 || cnt !== 3'd0)
            $display("FAIL drain_empty: o_vld=%b o_dat=%h cnt=%0d want 0 00 0", o_vld, o_dat, cnt);
        else passes++;
        o_rdy = 0;
    endtask

    task automatic test_streaming();
        i_vld = 1; o_rdy = 1;
        for (int k = 0; k < 16; k++) begin
            i_dat = 8'(k);
            tick();
            checks++;
            if (o_vld !== 1'b1 || o_dat !== 8'(k) || cnt !== 3'd1)
                $display("FAIL stream%0d: o_vld=%b o_dat=%h cnt=%0d want 1 %h 1",
                         k, o_vld, o_dat, cnt, 8'(k));
            else passes++;
        end
        i_vld = 0;
        tick();
        checks++;
        if (o_vld !== 1'b0 || cnt !== 3'd0)
            $display("FAIL stream_end: o_vld=%b cnt=%0d want 0 0", o_vld, cnt);
        else passes++;
        o_rdy = 0;
    endtask

    task automatic test_full_pop_push();
        logic [DW-1:0] exp[4];
        o_rdy = 0; i_vld = 1;
        for (int i = 0; i < 4; i++) begin
            i_dat = 8'(8'hA0 + i);
            tick();
        end
        i_dat = 8'hB0; o_rdy = 1;
        checks++;
        if (o_dat !== 8'hA0 || i_rdy !== 1'b0)
            $display("FAIL full_head: o_dat=%h i_rdy=%b want a0 0", o_dat, i_rdy);
        else passes++;
        tick();
        checks++;
        if (cnt !== 3'd3 || o_dat !== 8'hA1 || i_rdy !== 1'b1)
            $display("FAIL full_pop: cnt=%0d o_dat=%h i_rdy=%b want 3 a1 1", cnt, o_dat, i_rdy);
        else passes++;
        o_rdy = 0;
        tick();
        checks++;
        if (cnt !== 3'd4)
            $display("FAIL full_retry: cnt=%0d want 4", cnt);
        else passes++;
        i_vld = 0; o_rdy = 1;
        exp = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_dat !== exp[i])
                $display("FAIL full_drain%0d: o_dat=%h want %h", i, o_dat, exp[i]);
            else passes++;
            tick();
        end
        o_rdy = 0;
    endtask

    task automatic test_reset_mid();
        o_rdy = 0; i_vld = 1;
        for (int i = 0; i < 3; i++) begin
            i_dat = 8'(8'h30 + i);
            tick();
        end
        checks++;
        if (cnt !== 3'd3)
            $display("FAIL mid_pre: cnt=%0d want 3", cnt);
        else passes++;
        rst = 1; i_dat = 8'h99;
        tick();
        rst = 0;
        checks++;
        if (cnt !== 3'd0 || o_vld !== 1'b0 || o_dat !== 8'h00)
            $display("FAIL mid_rst: cnt=%0d o_vld=%b o_dat=%h want 0 0 00", cnt, o_vld, o_dat);
        else passes++;
        i_dat = 8'h77;
        tick();
        i_vld = 0;
        checks++;
        if (o_dat !== 8'h77 || cnt !== 3'd1)
            $display("FAIL mid_first: o_dat=%h cnt=%0d want 77 1", o_dat, cnt);
        else passes++;
        o_rdy = 1;
        tick();
        o_rdy = 0;
        checks++;
        if (o_vld !== 1'b0)
            $display("FAIL mid_drain: o_vld=%b want 0", o_vld);
        else passes++;
    endtask

    task automatic test_random_stress();
        logic [DW-1:0] exp;
        logic [2:0]    pdiff;
        int            sz;
        for (int c = 0; c < 10000; c++) begin
            i_vld = 1'($urandom_range(0, 1));
            o_rdy = 1'($urandom_range(0, 1));
            i_dat = 8'($urandom);
            tick();
            sz  = model.size();
            exp = (sz != 0) ? model[0] : 8'h00;
            pdiff = dut.wptr_q - dut.rptr_q;
            checks++;
            if (cnt !== 3'(sz) || cnt > 3'd4 || i_rdy !== (sz != 4) ||
                o_vld !== (sz != 0) || o_dat !== exp || pdiff !== cnt)
                $display("FAIL stress%0d: cnt=%0d i_rdy=%b o_vld=%b o_dat=%h ptrdiff=%0d want %0d %b %b %h",
                         c, cnt, i_rdy, o_vld, o_dat, pdiff, sz, sz != 4, sz != 0, exp);
            else passes++;
        end
        i_vld = 0; o_rdy = 0;
    endtask

    initial begin
        rst = 1; i_vld = 0; o_rdy = 0; i_dat = '0;
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop_push();
        test_reset_mid();
        test_random_stress();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
